// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 receive path.
//   FRAME_BITS  : bits in one device-to-host frame (start, 8 data, parity, stop)
//   START_IDX   : frame index of the start bit
//   PARITY_IDX  : frame index of the odd-parity bit
//   STOP_IDX    : frame index of the stop bit
//   IDX_W       : width of the frame bit index
//   count_w()   : width of a FIFO occupancy count able to hold 0..depth
// ----------------------------------------------------------------------------
package ps2_pkg;

   localparam int FRAME_BITS = 11;
   localparam int START_IDX  = 0;
   localparam int PARITY_IDX = 9;
   localparam int STOP_IDX   = 10;
   localparam int IDX_W      = $clog2(FRAME_BITS);

   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ----------------------------------------------------------------------------
// ps2_clk_filter
// Brings the asynchronous PS/2 pins into the clk domain, de-glitches the PS/2
// clock and produces a one-cycle pulse on each filtered falling edge.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock pin
//   ps2_data   : raw PS/2 data pin
//   sample     : one-cycle pulse, filtered ps2_clk went 1 -> 0
//   data_sync  : synchronised ps2_data, valid to sample while sample=1
// ----------------------------------------------------------------------------
module ps2_clk_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic sample,
   output logic data_sync
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       clk_meta;
   logic [1:0]       data_meta;
   logic             clk_filt;
   logic [CNT_W-1:0] stable_cnt;

   // stable_cnt counts consecutive cycles in which the synchronised clock
   // disagrees with the filtered one; any agreeing cycle restarts the count,
   // so pulses shorter than FILTER_LEN cycles never reach clk_filt.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta   <= 2'b11;
         data_meta  <= 2'b11;
         clk_filt   <= 1'b1;
         stable_cnt <= '0;
         sample     <= 1'b0;
      end else begin
         clk_meta  <= {clk_meta[0], ps2_clk};
         data_meta <= {data_meta[0], ps2_data};
         sample    <= 1'b0;
         if (clk_meta[1] == clk_filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
            clk_filt   <= clk_meta[1];
            stable_cnt <= '0;
            // Only a 1 -> 0 change of the filtered clock is a sample point.
            sample     <= clk_filt;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

   assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver: assembles 11-bit frames into scan codes and
// queues valid codes in a show-ahead FIFO, with sticky error reporting.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   ps2_clk     : raw PS/2 clock pin (asynchronous)
//   ps2_data    : raw PS/2 data pin (asynchronous)
//   rd          : pop head entry, ignored while FIFO empty
//   clr_err     : clear overflow/parity_err/frame_err (a same-cycle set wins)
//   data        : head entry, 8'h00 while empty
//   ready       : FIFO non-empty
//   count       : FIFO occupancy
//   overflow    : sticky, valid frame dropped on full FIFO
//   parity_err  : sticky, odd-parity check failed
//   frame_err   : sticky, bad stop bit or frame timeout
// ----------------------------------------------------------------------------
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   input  logic                        rd,
   input  logic                        clr_err,
   output logic [7:0]                  data,
   output logic                        ready,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        overflow,
   output logic                        parity_err,
   output logic                        frame_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = count_w(FIFO_DEPTH);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             sample;
   logic             sdata;
   logic [IDX_W-1:0] idx;
   logic [7:0]       shreg;
   logic             par_bit;
   logic [TMO_W-1:0] tmo_cnt;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] cnt;

   logic stop_smp;
   logic parity_ok;
   logic stop_ok;
   logic push_req;
   logic full;
   logic pop;
   logic push;
   logic timeout;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .sample    (sample),
      .data_sync (sdata)
   );

   // ---------------------------------------------------------------------
   // Frame checks, evaluated in the stop-bit sample cycle
   // ---------------------------------------------------------------------
   always_comb begin
      stop_smp  = sample && (idx == IDX_W'(STOP_IDX));
      parity_ok = ^{shreg, par_bit};
      stop_ok   = sdata;
      push_req  = stop_smp && parity_ok && stop_ok;
      full      = (cnt == CNT_W'(FIFO_DEPTH));
      pop       = rd && (cnt != '0);
      // A full FIFO still accepts the push when a pop frees the slot.
      push      = push_req && (!full || pop);
      timeout   = !sample && (idx != '0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
   end

   // ---------------------------------------------------------------------
   // Frame assembly and in-frame timeout
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tmo_cnt <= '0;
      end else if (sample) begin
         tmo_cnt <= '0;
         if (idx == IDX_W'(START_IDX)) begin
            // A high level here is noise, not a start bit: stay put.
            if (!sdata) idx <= idx + 1'b1;
         end else if (idx < IDX_W'(PARITY_IDX)) begin
            shreg <= {sdata, shreg[7:1]};   // LSB arrives first
            idx   <= idx + 1'b1;
         end else if (idx == IDX_W'(PARITY_IDX)) begin
            par_bit <= sdata;
            idx     <= idx + 1'b1;
         end else begin
            idx <= '0;
         end
      end else if (idx != '0) begin
         if (timeout) begin
            idx     <= '0;
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end else begin
         tmo_cnt <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Sticky flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow   <= (overflow & ~clr_err)   | (push_req && full && !pop);
         parity_err <= (parity_err & ~clr_err) | (stop_smp && !parity_ok);
         frame_err  <= (frame_err & ~clr_err)  | (stop_smp && !stop_ok) | timeout;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage (contents survive reset)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign count = cnt;
   assign ready = (cnt != '0);
   assign data  = ready ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Self-checking bench for ps2_rx_fifo. A reference model (queue of expected
// FIFO contents plus expected flag values) is updated per frame sent; a
// monitor pops the model on every rd and compares the DUT head entry.
// ----------------------------------------------------------------------------
module tb_ps2_rx_fifo;

   localparam int DEPTH = 8;
   localparam int FLEN  = 4;
   localparam int TMO   = 300;
   localparam int H     = 12;   // clk cycles per PS/2 clock half period

   logic       clk;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd;
   logic       clr_err;
   logic [7:0] data;
   logic       ready;
   logic [3:0] count;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;

   ps2_rx_fifo #(
      .FIFO_DEPTH     (DEPTH),
      .FILTER_LEN     (FLEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rd         (rd),
      .clr_err    (clr_err),
      .data       (data),
      .ready      (ready),
      .count      (count),
      .overflow   (overflow),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic       exp_ovf;
   logic       exp_par;
   logic       exp_frm;
   int         n_total;
   int         n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && rd) begin
         chk("rd_ready", 32'(ready), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) chk("rd_data", 32'(data), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Device-to-host frame. nbits < 11 sends a truncated frame. glitch adds
   // 2-cycle pulses on ps2_clk in both half periods. rd_on_push pulses rd in
   // the cycle the stop bit is sampled (fall + sync + filter latency).
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit glitch, input bit rd_on_push);
      logic [10:0] f;
      f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (glitch) begin
            idle(4); ps2_clk = 1'b0; idle(2); ps2_clk = 1'b1; idle(H - 6);
         end else begin
            idle(H);
         end
         ps2_clk = 1'b0;
         if (rd_on_push && i == 10) begin
            idle(6); rd = 1'b1; tick(); rd = 1'b0; idle(H - 7);
         end else if (glitch) begin
            idle(8); ps2_clk = 1'b1; idle(2); ps2_clk = 1'b0; idle(H - 10);
         end else begin
            idle(H);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      idle(20);
   endtask

   // Reference model: apply the frame-level rules to the expected state.
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      if (bad_par)  exp_par = 1'b1;
      if (bad_stop) exp_frm = 1'b1;
      if (!bad_par && !bad_stop) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else exp_ovf = 1'b1;
      end
   endtask

   task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      send_frame(d, bad_par, bad_stop, 11, 1'b0, 1'b0);
      model_frame(d, bad_par, bad_stop);
   endtask

   task automatic pop_one();
      tick(); rd = 1'b1; tick(); rd = 1'b0;
   endtask

   task automatic clear_errors();
      tick(); clr_err = 1'b1; tick(); clr_err = 1'b0;
      exp_ovf = 1'b0; exp_par = 1'b0; exp_frm = 1'b0;
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      chk({tag, ".count"},      32'(count),      32'(exp_q.size()));
      chk({tag, ".ready"},      32'(ready),      32'(exp_q.size() != 0));
      chk({tag, ".data"},       32'(data),       (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      chk({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
      chk({tag, ".parity_err"}, 32'(parity_err), 32'(exp_par));
      chk({tag, ".frame_err"},  32'(frame_err),  32'(exp_frm));
      tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_total = 0; n_pass = 0;
      exp_ovf = 1'b0; exp_par = 1'b0; exp_frm = 1'b0;
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; clr_err = 1'b0;
      idle(5);
      reset = 1'b0;
      check_status("reset");

      // single frame round trip
      frame(8'h1C, 1'b0, 1'b0);
      check_status("one_frame");
      pop_one();
      check_status("one_pop");

      // fill past depth: the ninth frame is dropped
      for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0);
      check_status("fill_ovf");
      repeat (DEPTH) pop_one();
      check_status("drained");
      clear_errors();
      check_status("clr_ovf");

      // parity error then stop error
      frame(8'hF0, 1'b1, 1'b0);
      frame(8'h1C, 1'b0, 1'b1);
      check_status("bad_frames");
      clear_errors();
      check_status("clr_bad");

      // truncated frame times out, next frame is clean
      send_frame(8'hA5, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      idle(TMO + 5);
      exp_frm = 1'b1;
      check_status("timeout");
      frame(8'h29, 1'b0, 1'b0);
      check_status("after_timeout");
      pop_one();
      clear_errors();

      // glitchy ps2_clk
      send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1, 1'b0);
      model_frame(8'h5A, 1'b0, 1'b0);
      check_status("glitch");
      pop_one();

      // full FIFO, pop in the same cycle as the push
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      check_status("full");
      send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b1);
      model_frame(8'h33, 1'b0, 1'b0);
      check_status("push_pop_full");
      repeat (DEPTH) pop_one();
      check_status("drained2");

      // randomized traffic
      for (int it = 0; it < 24; it++) begin
         int kind;
         int npop;
         logic [7:0] d;
         d    = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 9);
         frame(d, kind == 0, kind == 1);
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++) pop_one();
         if ($urandom_range(0, 5) == 0) clear_errors();
         check_status("random");
      end
      while (exp_q.size() != 0) pop_one();
      pop_one();   // rd on an empty FIFO
      check_status("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver: the next generation of the team's keyboard front end.
- Deserialises 11-bit PS/2 frames into 8-bit scan codes and queues them in a FIFO of configurable depth.
- Adds over the previous generation: ps2_clk glitch filter, start-bit resync, frame timeout, drop-on-full policy, separate sticky error flags with clear, and a fill-level output.
- Sits between the PS/2 pins and the keyboard/MMIO consumer in the npc SoC.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; power of two, at least 2.
- FILTER_LEN, 4, number of consecutive identical synchronised samples required before the filtered ps2_clk changes; at least 1.
- TIMEOUT_CYCLES, 50000, clk cycles allowed between sample pulses inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- rd  in  1  pop the head entry; honoured only when ready=1.
- clr_err  in  1  clears overflow, parity_err and frame_err.
- data  out  8  FIFO head entry (show-ahead); 8'h00 when empty.
- ready  out  1  FIFO non-empty.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame failed the odd-parity check.
- frame_err  out  1  sticky: bad stop bit, or frame timeout.

Behaviour:
- Reset, with reset sampled high on a clk edge:
  - data=0, ready=0, count=0, all flags=0.
  - Pointers, bit counter and timeout counter cleared; filtered ps2_clk=1.
  - FIFO RAM is not cleared.
  - A reset mid-frame discards the partial frame.
- Input path:
  - ps2_clk and ps2_data each pass through 2-flop synchronisers.
  - The filtered clock takes the synchronised ps2_clk value once it has been stable for FILTER_LEN consecutive cycles.
  - A 1→0 transition of the filtered clock produces a one-cycle sample pulse; ps2_data is sampled in that cycle.
- Frame assembly (bit index 0..10):
  - Index 0 requires data=0 (start bit). A 1 is ignored and the index stays at 0, which resyncs on noise.
  - Indices 1..8 are data LSB-first; index 9 is parity; index 10 is stop.
- Frame check, on the index-10 sample pulse:
  - Parity check: the XOR of data[7:0] and the parity bit must be 1 (odd parity).
  - Stop check: the stop bit must be 1.
  - Both pass: frame is valid and is pushed.
  - Parity fails: set parity_err, no push.
  - Stop fails: set frame_err, no push.
  - Both fail: set both flags, no push.
  - The index returns to 0 in every case.
- Timeout:
  - A counter runs while the index is non-zero and clears on every sample pulse.
  - When it reaches TIMEOUT_CYCLES: index←0, frame_err set, no push.
- Push:
  - Occurs in the cycle of the stop-bit sample pulse; ready/count update on the next clk edge.
  - If the FIFO is full with no simultaneous pop, the frame is dropped and overflow is set. Existing entries are never overwritten.
- Pop:
  - rd=1 with ready=1 advances the read pointer; data shows the next entry the following cycle.
  - rd with an empty FIFO is ignored.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees a slot; no overflow.
- Pointers: width $clog2(FIFO_DEPTH) with natural wrap; full/empty are derived from count.
- Flags: clr_err clears all three flags; if a set event occurs in the same cycle, set wins.

Decomposition:
- Package ps2_pkg holds:
  - FRAME_BITS=11, START_IDX=0, PARITY_IDX=9, STOP_IDX=10.
  - Localparam helper for the count width.
- Sub-module ps2_clk_filter: synchroniser plus stability filter plus falling-edge detect. Outputs the sample pulse and synchronised data, and is reusable by a future PS/2 mouse receiver.
- FIFO storage stays inline.

Test Plan:
- Send frame 0x1C (odd parity bit=0, stop=1) → 8-10 clk after the filtered stop edge ready=1, data=8'h1C, count=1; pulse rd → ready=0, count=0, data=8'h00.
- Send 9 valid frames 0x01..0x09 with FIFO_DEPTH=8 and no reads → count=8, overflow=1; 8 pops yield 0x01..0x08; 0x09 is lost.
- Send 0xF0 with a wrong parity bit, then 0x1C with stop=0 → no push; parity_err=1, frame_err=1; assert clr_err → both flags 0.
- Send 4 bits of a frame then idle TIMEOUT_CYCLES+5 cycles → frame_err=1; a following valid 0x29 is received correctly.
- Inject 2-cycle glitches on ps2_clk (FILTER_LEN=4) during a frame of 0x5A → data=8'h5A, no error flags.
- With FIFO full, pulse rd in the same cycle as the push of 0x33 → count stays 8, overflow=0, 0x33 becomes the last entry.
